// File: rtl/param_ser_pkg.sv
// Shared types and sizing helpers for the parameterised word-to-slice serializer.
package param_ser_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_INIT = 2'd1,
    SHIFT     = 2'd2
  } state_e;

  function automatic int num_slices(input int word_w, input int slice_w);
    return (slice_w > 0) ? (word_w / slice_w) : 1;
  endfunction

  // A single-slice word still needs a 1-bit index port.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/param_word_serializer.sv
// Accepts one word on a valid/ready input and emits it as NUM_SLICES slices on a
// valid/ready output, optionally self-loading INIT_WORD once after each reset.
module param_word_serializer
  import param_ser_pkg::*;
#(
  parameter int          WORD_WIDTH  = 16,
  parameter int          SLICE_WIDTH = 8,
  parameter bit          MSB_FIRST   = 1'b1,
  parameter bit          AUTO_LOAD   = 1'b0,
  parameter logic [63:0] INIT_WORD   = 64'h1234
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               in_valid,
  output logic                                               in_ready,
  input  logic [WORD_WIDTH-1:0]                              in_word,
  output logic                                               out_valid,
  input  logic                                               out_ready,
  output logic [SLICE_WIDTH-1:0]                             out_slice,
  output logic [idx_width(num_slices(WORD_WIDTH, SLICE_WIDTH))-1:0] out_index,
  output logic                                               out_last,
  output logic                                               busy,
  output logic [15:0]                                        words_done
);

  localparam int                    NUM_SLICES  = num_slices(WORD_WIDTH, SLICE_WIDTH);
  localparam int                    IDX_W       = idx_width(NUM_SLICES);
  localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(NUM_SLICES - 1);
  localparam logic [WORD_WIDTH-1:0] INIT_VAL    = WORD_WIDTH'(INIT_WORD);
  localparam state_e                RESET_STATE = AUTO_LOAD ? LOAD_INIT : IDLE;

  generate
    if ((SLICE_WIDTH < 1) || (WORD_WIDTH < 1) || ((WORD_WIDTH % SLICE_WIDTH) != 0)) begin : g_bad_params
      $fatal(1, "param_word_serializer: WORD_WIDTH must be a nonzero multiple of SLICE_WIDTH");
    end
  endgenerate

  state_e                r_state;
  state_e                w_state_nxt;
  logic [WORD_WIDTH-1:0] r_word;
  logic [IDX_W-1:0]      r_index;
  logic [15:0]           r_words_done;
  logic                  w_load;
  logic [WORD_WIDTH-1:0] w_load_word;
  logic                  w_advance;
  logic                  w_done;
  logic                  w_shift;
  logic                  w_last;
  logic [IDX_W-1:0]      w_sel;

  assign w_shift = (r_state == SHIFT);
  assign w_last  = w_shift && (r_index == LAST_IDX);
  // Emission position k maps to a physical slice; MSB-first walks from the top.
  assign w_sel   = MSB_FIRST ? (LAST_IDX - r_index) : r_index;

  assign in_ready   = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign out_valid  = w_shift;
  assign out_last   = w_last;
  assign out_index  = r_index;
  assign out_slice  = r_word[int'(w_sel) * SLICE_WIDTH +: SLICE_WIDTH];
  assign words_done = r_words_done;

  // Next-state and datapath control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_word = in_word;
    w_advance   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      LOAD_INIT: begin
        w_load      = 1'b1;
        w_load_word = INIT_VAL;
        w_state_nxt = SHIFT;
      end
      SHIFT: begin
        if (out_ready && w_last) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else if (out_ready) begin
          w_advance   = 1'b1;
        end else begin
          w_state_nxt = SHIFT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, word, index and completed-word counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RESET_STATE;
      r_word       <= '0;
      r_index      <= '0;
      r_words_done <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_word  <= w_load_word;
        r_index <= '0;
      end else if (w_advance) begin
        r_index <= r_index + IDX_W'(1);
      end
      if (w_done) begin
        r_words_done <= r_words_done + 16'd1;
      end
    end
  end

endmodule
